// File: rtl/mpi_pkg.sv
// Shared types and constants for the MPI bus target: FSM states, the start-address
// register location and the registered bus-input bundle.
package mpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_RWAIT,
    ST_RREPLY,
    ST_WREPLY
  } mpi_state_t;

  localparam logic [15:0] START_REG_ADDR = 16'o177716;

  typedef struct packed {
    logic        init_n;
    logic [15:0] ad_n;
    logic        sync_n;
    logic        din_n;
    logic        dout_n;
    logic        wtbt_n;
    logic [1:0]  sel_n;
  } bus_in_t;

  localparam bus_in_t BUS_IDLE = '{init_n: 1'b1, ad_n: 16'hFFFF, sync_n: 1'b1,
                                   din_n: 1'b1, dout_n: 1'b1, wtbt_n: 1'b1,
                                   sel_n: 2'b11};

endpackage

// File: rtl/mpi_regfile.sv
// Byte-writable 16-bit register file with synchronous clear and flat readout.
module mpi_regfile #(
  parameter int NREG = 8,
  parameter int IW   = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      we,
  input  logic [IW-1:0]             idx,
  input  logic [15:0]               wdata,
  input  logic [1:0]                bmask,
  output logic [15:0]               rdata,
  output logic [NREG-1:0][15:0]     regs
);

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    always_ff @(posedge clk) begin
      if (clr) begin
        regs[g] <= '0;
      end else if (we && idx == IW'(g)) begin
        if (bmask[0]) regs[g][7:0]  <= wdata[7:0];
        if (bmask[1]) regs[g][15:8] <= wdata[15:8];
      end
    end
  end

  assign rdata = regs[idx];

endmodule

// File: rtl/mpi_target.sv
// MPI bus target: registers the bus, decodes a register window plus the read-only
// start-address location, and runs the DIN/DOUT handshake FSM.
module mpi_target
  import mpi_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'o177700,
  parameter int          NREG       = 8,
  parameter int          RD_WAIT    = 1,
  parameter logic [15:0] START_ADDR = 16'd256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_n,
  input  logic [15:0]          ad_n_i,
  output logic [15:0]          ad_n_o,
  output logic                 ad_oe,
  input  logic                 sync_n,
  input  logic                 din_n,
  input  logic                 dout_n,
  input  logic                 wtbt_n,
  input  logic [1:0]           sel_n,
  output logic                 rply_n,
  output logic [NREG*16-1:0]   regs_o
);

  localparam int          IW = $clog2(NREG);
  localparam logic [3:0]  RW = 4'(RD_WAIT);

  bus_in_t    bq;
  logic       sync_d;
  mpi_state_t state, nxt_state;
  logic [3:0] cnt, nxt_cnt;
  logic       oe_q, nxt_oe, rply_q, nxt_rply;
  logic [15:0] ad_q, nxt_ad;
  logic [IW-1:0] idx_q, nxt_idx;
  logic       a0_q, nxt_a0, start_q, nxt_start;
  logic       we;
  logic [1:0] bmask;
  logic [15:0] rdata;
  logic [NREG-1:0][15:0] regs;

  wire clr       = rst | ~bq.init_n;
  wire sync_fall = sync_d & ~bq.sync_n;
  wire [15:0] addr_now = ~bq.ad_n;
  wire [15:0] word_now = {1'b0, addr_now[15:1]};
  wire [15:0] base_w   = {1'b0, BASE_ADDR[15:1]};
  wire start_now = (addr_now == START_REG_ADDR) && (bq.sel_n == 2'b10);
  // The start-address word is reserved even when it overlaps the window.
  wire win_now   = (word_now >= base_w) && (word_now < base_w + 16'(NREG)) &&
                   (addr_now != START_REG_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      bq     <= BUS_IDLE;
      sync_d <= 1'b1;
    end else begin
      bq     <= '{init_n: init_n, ad_n: ad_n_i, sync_n: sync_n, din_n: din_n,
                  dout_n: dout_n, wtbt_n: wtbt_n, sel_n: sel_n};
      sync_d <= bq.sync_n;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      oe_q    <= 1'b0;
      rply_q  <= 1'b1;
      ad_q    <= 16'hFFFF;
      idx_q   <= '0;
      a0_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      oe_q    <= nxt_oe;
      rply_q  <= nxt_rply;
      ad_q    <= nxt_ad;
      idx_q   <= nxt_idx;
      a0_q    <= nxt_a0;
      start_q <= nxt_start;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_oe    = oe_q;
    nxt_rply  = rply_q;
    nxt_ad    = ad_q;
    nxt_idx   = idx_q;
    nxt_a0    = a0_q;
    nxt_start = start_q;
    we        = 1'b0;
    if (sync_fall) begin
      nxt_idx   = addr_now[1 +: IW];
      nxt_a0    = addr_now[0];
      nxt_start = start_now;
    end
    case (state)
      ST_IDLE:   if (sync_fall && (start_now || win_now)) nxt_state = ST_SEL;
      ST_SEL: begin
        if (!bq.din_n) begin
          nxt_state = ST_RWAIT;
          nxt_cnt   = '0;
        end else if (!bq.dout_n) begin
          we        = ~start_q;
          nxt_rply  = 1'b0;
          nxt_state = ST_WREPLY;
        end
      end
      ST_RWAIT: begin
        if (bq.din_n) begin
          nxt_state = ST_SEL;
        end else if (cnt == RW) begin
          nxt_ad    = start_q ? ~START_ADDR : ~rdata;
          nxt_oe    = 1'b1;
          nxt_rply  = 1'b0;
          nxt_state = ST_RREPLY;
        end else begin
          nxt_cnt = cnt + 4'd1;
        end
      end
      ST_RREPLY: if (bq.din_n) begin
        nxt_oe    = 1'b0;
        nxt_rply  = 1'b1;
        nxt_ad    = 16'hFFFF;
        nxt_state = ST_SEL;
      end
      ST_WREPLY: if (bq.dout_n) begin
        nxt_rply  = 1'b1;
        nxt_state = ST_SEL;
      end
      default:   nxt_state = ST_IDLE;
    endcase
    // SYNC release aborts any cycle, including a write not yet committed.
    if (bq.sync_n && state != ST_IDLE) begin
      we        = 1'b0;
      nxt_oe    = 1'b0;
      nxt_rply  = 1'b1;
      nxt_ad    = 16'hFFFF;
      nxt_state = ST_IDLE;
    end
  end

  assign bmask  = bq.wtbt_n ? 2'b11 : (a0_q ? 2'b10 : 2'b01);
  assign ad_oe  = oe_q & ~bq.din_n;
  assign ad_n_o = ad_q;
  assign rply_n = rply_q;
  assign regs_o = regs;

  mpi_regfile #(.NREG(NREG), .IW(IW)) u_regfile (
    .clk   (clk),
    .clr   (clr),
    .we    (we),
    .idx   (idx_q),
    .wdata (~bq.ad_n),
    .bmask (bmask),
    .rdata (rdata),
    .regs  (regs)
  );

endmodule

// File: tb/tb_mpi_target.sv
// Scoreboard bench for mpi_target: stimulus queues expected replies, a monitor
// checks each rply_n assertion; a second RD_WAIT=4 instance covers the SYNC abort.
module tb_mpi_target;
  import mpi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, init_n = 1'b1;
  logic [15:0] ad_n_i = 16'hFFFF;
  logic sync_n = 1'b1, din_n = 1'b1, dout_n = 1'b1, wtbt_n = 1'b1;
  logic [1:0] sel_n = 2'b11;
  logic [15:0] ad_n_o;
  logic ad_oe, rply_n;
  logic [127:0] regs_o;

  logic [15:0] ad4_n_i = 16'hFFFF;
  logic sync4_n = 1'b1, din4_n = 1'b1;
  logic [15:0] ad4_n_o;
  logic ad4_oe, rply4_n;
  logic [127:0] regs4_o;

  mpi_target u_dut (
    .clk(clk), .rst(rst), .init_n(init_n), .ad_n_i(ad_n_i), .ad_n_o(ad_n_o),
    .ad_oe(ad_oe), .sync_n(sync_n), .din_n(din_n), .dout_n(dout_n),
    .wtbt_n(wtbt_n), .sel_n(sel_n), .rply_n(rply_n), .regs_o(regs_o)
  );

  mpi_target #(.RD_WAIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .init_n(1'b1), .ad_n_i(ad4_n_i), .ad_n_o(ad4_n_o),
    .ad_oe(ad4_oe), .sync_n(sync4_n), .din_n(din4_n), .dout_n(1'b1),
    .wtbt_n(1'b1), .sel_n(2'b11), .rply_n(rply4_n), .regs_o(regs4_o)
  );

  typedef struct { logic rd; logic [15:0] data; } exp_t;
  exp_t expq[$];
  exp_t e;
  int n_cmp = 0, n_err = 0;
  int reply_cnt = 0, oe_cnt = 0, oe4_cnt = 0, rply4_cnt = 0;
  logic rply_prev = 1'b1;
  logic [127:0] exp_regs = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (ad_oe) oe_cnt++;
      if (ad4_oe) oe4_cnt++;
      if (!rply4_n) rply4_cnt++;
      if (!rply_n && rply_prev) begin
        reply_cnt++;
        n_cmp++;
        if (expq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_reply: ad_oe=%0b ad_n_o=%h, no reply was expected", ad_oe, ad_n_o);
        end else begin
          e = expq.pop_front();
          if (ad_oe !== e.rd || (e.rd && ad_n_o !== ~e.data)) begin
            n_err++;
            $display("FAIL reply: ad_oe=%0b ad_n_o=%h, required ad_oe=%0b ad_n_o=%h",
                     ad_oe, ad_n_o, e.rd, e.rd ? ~e.data : ad_n_o);
          end
        end
      end
      rply_prev = rply_n;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rply(input logic lvl, input string nm);
    int k = 0;
    while (rply_n !== lvl && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (rply_n !== lvl) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout, rply_n=%b, required %b", nm, rply_n, lvl);
    end
  endtask

  task automatic sync_start(input logic [15:0] addr, input logic [1:0] sel);
    ad_n_i = ~addr;
    sel_n  = sel;
    tick(1);
    sync_n = 1'b0;
    tick(3);
    ad_n_i = 16'hFFFF;
  endtask

  task automatic sync_end();
    sync_n = 1'b1;
    sel_n  = 2'b11;
    tick(4);
  endtask

  task automatic do_read(input logic [15:0] data, input string nm);
    expq.push_back('{rd: 1'b1, data: data});
    din_n = 1'b0;
    wait_rply(1'b0, nm);
    din_n = 1'b1;
    wait_rply(1'b1, nm);
  endtask

  task automatic do_write(input logic [15:0] data, input logic wtbt, input string nm);
    expq.push_back('{rd: 1'b0, data: 16'h0000});
    ad_n_i = ~data;
    wtbt_n = wtbt;
    dout_n = 1'b0;
    wait_rply(1'b0, nm);
    dout_n = 1'b1;
    ad_n_i = 16'hFFFF;
    wtbt_n = 1'b1;
    wait_rply(1'b1, nm);
  endtask

  initial begin
    int r0, o0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_rply_n", 128'(rply_n), 128'(1'b1));
    chk("rst_ad_oe", 128'(ad_oe), 128'(1'b0));
    chk("rst_ad_n_o", 128'(ad_n_o), 128'(16'hFFFF));
    chk("rst_regs", regs_o, '0);

    // word write then read back
    sync_start(16'o177700, 2'b11); do_write(16'h1234, 1'b1, "wr_r0"); sync_end();
    exp_regs[15:0] = 16'h1234;
    chk("reg0_word", regs_o, exp_regs);
    sync_start(16'o177700, 2'b11); do_read(16'h1234, "rd_r0"); sync_end();

    // byte writes into reg1
    sync_start(16'o177702, 2'b11); do_write(16'h5555, 1'b1, "wr_r1"); sync_end();
    sync_start(16'o177703, 2'b11); do_write(16'hAB00, 1'b0, "wrb_hi"); sync_end();
    exp_regs[31:16] = 16'hAB55;
    chk("reg1_byte_hi", regs_o, exp_regs);
    sync_start(16'o177702, 2'b11); do_write(16'h12CD, 1'b0, "wrb_lo"); sync_end();
    exp_regs[31:16] = 16'hABCD;
    chk("reg1_byte_lo", regs_o, exp_regs);

    // start address: selected vs not selected
    sync_start(16'o177716, 2'b10); do_read(16'd256, "rd_start"); sync_end();
    r0 = reply_cnt; o0 = oe_cnt;
    sync_start(16'o177716, 2'b11); din_n = 1'b0; tick(20); din_n = 1'b1; sync_end();
    chk("start_unsel_rply", 128'(reply_cnt - r0), 128'(0));
    chk("start_unsel_oe", 128'(oe_cnt - o0), 128'(0));
    sync_start(16'o177716, 2'b10); do_write(16'h1111, 1'b1, "wr_start"); sync_end();
    chk("start_wr_noeffect", regs_o, exp_regs);

    // unmapped address
    r0 = reply_cnt; o0 = oe_cnt;
    sync_start(16'o001000, 2'b11); din_n = 1'b0; tick(50); din_n = 1'b1; sync_end();
    chk("unmapped_rply", 128'(reply_cnt - r0), 128'(0));
    chk("unmapped_oe", 128'(oe_cnt - o0), 128'(0));

    // read-modify-write in one SYNC
    r0 = reply_cnt;
    sync_start(16'o177704, 2'b11);
    do_read(16'h0000, "rmw_rd");
    do_write(16'h00FF, 1'b1, "rmw_wr");
    sync_end();
    exp_regs[47:32] = 16'h00FF;
    chk("rmw_replies", 128'(reply_cnt - r0), 128'(2));
    chk("rmw_regs", regs_o, exp_regs);

    // INIT clears the register file
    init_n = 1'b0; tick(3); init_n = 1'b1; tick(2);
    exp_regs = '0;
    chk("init_clear", regs_o, exp_regs);

    // SYNC released during RWAIT on the RD_WAIT=4 instance
    ad4_n_i = ~16'o177700; tick(1);
    sync4_n = 1'b0; tick(3);
    ad4_n_i = 16'hFFFF;
    din4_n = 1'b0; tick(2);
    chk("abort_in_rwait", 128'(u_dut4.state), 128'(ST_RWAIT));
    sync4_n = 1'b1; tick(2);
    chk("abort_idle", 128'(u_dut4.state), 128'(ST_IDLE));
    tick(8);
    din4_n = 1'b1; tick(2);
    chk("abort_no_oe", 128'(oe4_cnt), 128'(0));
    chk("abort_no_rply", 128'(rply4_cnt), 128'(0));

    chk("queue_drained", 128'(expq.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mpi_target.md
MPI_TARGET -- requirements
Module: mpi_target

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'o177700, the word-aligned base of the register window.
REQ-002 SHALL have parameter NREG, default 8, the number of 16-bit registers (power of two, 2..32).
REQ-003 SHALL have parameter RD_WAIT, default 1, the clocks from DIN sampled to data driven (0..15).
REQ-004 SHALL have parameter START_ADDR, default 16'd256, the value returned for a start-address read.
REQ-005 SHALL have ports: clk in 1, the only clock; rst in 1, reset, synchronous, active-high.
REQ-006 SHALL have port init_n in 1: bus INIT, active-low.
REQ-007 SHALL have port ad_n_i in 16: inverted AD bus, as sampled.
REQ-008 SHALL have port ad_n_o out 16: inverted AD drive value.
REQ-009 SHALL have port ad_oe out 1: high enables the AD drive.
REQ-010 SHALL have ports sync_n, din_n, dout_n, wtbt_n in 1 each: bus strobes, active-low.
REQ-011 SHALL have port sel_n in 2: processor select lines.
REQ-012 SHALL have port rply_n out 1: reply, active-low.
REQ-013 SHALL have port regs_o out NREG*16: flat register contents, reg0 in bits [15:0].

Function
REQ-014 SHALL register all bus inputs once; all decisions use the registered copies.
REQ-015 SHALL detect the SYNC falling edge as the registered sync_n going 1->0, and latch addr = ~ad_n_i on that edge.
REQ-016 SHALL be selected as a window hit when addr[15:1] lies in BASE_ADDR[15:1] .. BASE_ADDR[15:1]+NREG-1; the index is addr[1+:log2(NREG)].
REQ-017 SHALL be selected as a start hit when addr==16'o177716 and sel_n==2'b10 at the latch edge; a start hit is read-only.
REQ-018 SHALL implement the FSM IDLE -> SEL on the SYNC edge with a hit; with no hit it stays in IDLE until SYNC is released; SEL holds no outputs.
REQ-019 SHALL, in SEL with din low, go to RWAIT; after RWAIT, RD_WAIT clocks, drive ad_n_o=~data with ad_oe=1 and go to RREPLY, asserting rply_n=0 in that same clock.
REQ-020 SHALL, in RREPLY, keep driving until din is seen high, then deassert ad_oe and rply_n in the next clock and return to SEL.
REQ-021 SHALL, in SEL with dout low, write on the first clock and go to WREPLY with rply_n=0.
REQ-022 SHALL treat a write with wtbt_n low as a byte write: addr[0]=0 writes bits [7:0] from data[7:0]; addr[0]=1 writes bits [15:8] from data[15:8]; otherwise the whole word is written.
REQ-023 SHALL, in WREPLY, deassert rply_n once dout is high and return to SEL.
REQ-024 SHALL allow read-modify-write: a DIN then a DOUT inside one SYNC are both served.
REQ-025 SHALL, on a write to a start hit, assert rply_n but change no state.
REQ-026 SHALL give DIN priority when DIN and DOUT are both low in SEL, and ignore DOUT.
REQ-027 SHALL, when SYNC goes high in any state, return to IDLE, with ad_oe=0 and rply_n=1 from the next clock and no pending write committed.
REQ-028 SHALL, when init_n is low, clear all registers and force IDLE; it has the same effect as rst but is a separate input.
REQ-029 SHALL never assert ad_oe while registered din_n is high.

Reset
REQ-030 SHALL, on rst=1, set state=IDLE, ad_oe=0, ad_n_o=16'hFFFF, rply_n=1, all registers 0 and addr=0.
REQ-031 SHALL, when rst is asserted mid-transaction, release the bus at the next clock edge.

Structure
REQ-032 SHALL put the FSM state enumeration and the constant 16'o177716 in a shared package, mpi_pkg.
REQ-033 SHALL be split into an FSM/decoder and a sub-module mpi_regfile holding the byte-writable registers.

Verification
REQ-034 SHALL cover: a word write of 16'h1234 to 177700, then a read of 177700 -> rply_n=0, ad_n_o=~16'h1234, regs_o[15:0]=16'h1234.
REQ-035 SHALL cover: a byte write (wtbt_n=0) to 177703 with data 16'hAB00 over reg1=16'h5555 -> reg1=16'hAB55.
REQ-036 SHALL cover: a read of 177716 with sel_n=2'b10 -> ad_n_o=~16'd256; the same read with sel_n=2'b11 -> no rply_n and no ad_oe.
REQ-037 SHALL cover: SYNC/DIN to the unmapped address 001000 -> rply_n stays 1 and ad_oe stays 0 for 50 clocks.
REQ-038 SHALL cover: SYNC released during RWAIT with RD_WAIT=4 -> ad_oe and rply_n are never asserted and the FSM is in IDLE within 2 clocks.
REQ-039 SHALL cover: an RMW on 177704 (read 0, then write 16'h00FF in one SYNC) -> two replies and reg2=16'h00FF.
